qlearn_agent: RTL
=================

// Module: qlearn_agent
// PURPOSE
//  Parametrised tabular Q-learning agent for the dino game controller; successor to the fixed 32x3 bot.
//  - Accepts a decision request with (distance, obstacle type) and returns a jump/no-jump action via handshake.
//  - Latches the decision context and applies a reward update to exactly that table entry.
//  - Epsilon-greedy exploration, decaying epsilon with floor; sits between obstacle tracker and game FSM.
// PARAMETERS
//  DIST_W       10          width of distance input (pixels)
//  SECTOR_SHIFT 5           sector = distance >> SECTOR_SHIFT
//  NUM_SECTOR   32          table rows; sectors >= NUM_SECTOR clamp to NUM_SECTOR-1
//  OBST_W       3           width of obstacle type input
//  NUM_OBST     3           obstacle types; type >= NUM_OBST clamps to NUM_OBST-1
//  Q_W          8           Q-value width; Q_INIT = 2**(Q_W-1)
//  ALPHA_SHIFT  2           learning rate = 2**-ALPHA_SHIFT
//  EPS_INIT     16          epsilon after reset (0..255)
//  EPS_MIN      0           epsilon floor
//  EPS_PERIOD   10000000000 clk cycles between epsilon decrements (>=2)
//  CNT_W        34          width of epsilon-decay counter
// PORTS
//  clk        in  1       clock
//  reset      in  1       synchronous, active-high
//  req_valid  in  1       decision request
//  req_ready  out 1       agent idle, may accept request
//  distance   in  DIST_W  distance to closest obstacle, sampled on req accept
//  obst       in  OBST_W  closest obstacle type, sampled on req accept
//  act_valid  out 1       one-cycle pulse: action available
//  act_jump   out 1       1 = jump, 0 = no jump; held until next act_valid
//  act_explore out 1      1 = action was random exploration; held with act_jump
//  rew_valid  in  1       reward for the outstanding decision
//  rew_good   in  1       1 = positive reward, 0 = negative
//  abort      in  1       discard outstanding decision (game over / restart), no update
//  learn_en   in  1       0 = table frozen (rewards consumed, no write)
//  epsilon    out 8       current epsilon
// BEHAVIOUR
//  Reset: FSM=IDLE, all Q entries=Q_INIT, epsilon=EPS_INIT, counter=0, req_ready=1,
//   act_valid=0, act_jump=0, act_explore=0; LFSRs reload seeds. Reset mid-episode drops context.
//  FSM IDLE -> DECIDE -> WAIT_REW -> UPDATE -> IDLE.
//  - IDLE: req_ready=1; req_valid&req_ready latches sector(clamped), obst(clamped) -> DECIDE.
//    rew_valid in IDLE is ignored.
//  - DECIDE (1 cycle): if epsilon > rnd1, act = rnd2[7], explore=1;
//    else act = (Q[s][o][1] > Q[s][o][0]), explore=0 (tie -> no jump).
//    Latch act into context; act_valid pulses the following cycle; -> WAIT_REW.
//    Latency: act_valid asserted 2 cycles after request accept.
//  - WAIT_REW: req_ready=0; rew_valid -> UPDATE (rew_good latched); abort -> IDLE.
//    rew_valid and abort in same cycle: abort wins, no update.
//  - UPDATE (1 cycle): if learn_en, entry e = Q[s][o][act]:
//    good: e <= e + ((QMAX - e) >> ALPHA_SHIFT); bad: e <= e - (e >> ALPHA_SHIFT).
//    Arithmetic in Q_W bits, never wraps; QMAX = 2**Q_W-1. -> IDLE.
//    Only the single context entry is written; all other entries unchanged.
//  Epsilon: counter increments every cycle, independent of FSM; at EPS_PERIOD-1,
//   counter <= 0 and epsilon <= max(epsilon-1, EPS_MIN).
//  RNG: two free-running 8-bit LFSRs (distinct non-zero seeds) advance every cycle.
// STRUCTURE
//  qlearn_pkg: fsm state enum {IDLE, DECIDE, WAIT_REW, UPDATE}, ACT_NOJUMP/ACT_JUMP, helper for Q_INIT/QMAX.
//  Sub-module lfsr8 (seed parameter, clk, reset, out[7:0]), instantiated twice.
//  Q table: flat register array NUM_SECTOR*NUM_OBST*2 entries of Q_W, index {s,o,a}.
// TESTING
//  1 Reset, EPS_INIT=0: req distance=100, obst=1 -> act_valid 2 cycles later, act_jump=0 (tie), act_explore=0.
//  2 EPS_INIT=0: req d=64,o=0 -> rew good -> Q[2][0][0]=128+31=159; repeat -> 159+24=183; other entries stay 128.
//  3 Bad reward from 128 -> 96 -> 72; with learn_en=0 value unchanged; rew_valid+abort same cycle -> no write.
//  4 Clamp: distance=1023 (sector 31), obst=7 -> context indexes [31][2]; update lands there.
//  5 EPS_INIT=255: 200 decisions -> act_explore=1 always, both actions occur; EPS_PERIOD=4 -> epsilon steps 1 per 4 cycles to EPS_MIN.
//  6 Reset asserted in WAIT_REW -> next cycle req_ready=1, table all 128, later rew_valid ignored.

Source files
------------

// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning dino agent.
//  - state_e      : decision FSM states
//  - ACT_*        : action encoding (table column)
//  - q_init_val / q_max_val : Q-value midpoint and ceiling for a given width
package qlearn_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECIDE   = 2'd1,
    WAIT_REW = 2'd2,
    UPDATE   = 2'd3
  } state_e;

  localparam logic ACT_NOJUMP = 1'b0;
  localparam logic ACT_JUMP   = 1'b1;

  function automatic int q_init_val(input int q_w);
    return 1 << (q_w - 1);
  endfunction

  function automatic int q_max_val(input int q_w);
    return (1 << q_w) - 1;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
// Ports:
//  clk   in   clock
//  reset in   synchronous, active-high; reloads SEED
//  out   out  current LFSR state (never zero for a non-zero SEED)
module lfsr8 #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/qlearn_agent.sv
// Tabular Q-learning agent for the dino game controller.
// A request (distance, obstacle type) is turned into a jump/no-jump action
// with epsilon-greedy exploration; the decision context is kept until a
// reward arrives, which updates exactly that one table entry.
// Ports:
//  clk, reset              clock, synchronous active-high reset
//  req_valid / req_ready   decision request handshake
//  distance, obst          sampled when a request is accepted
//  act_valid               one-cycle pulse, two cycles after accept
//  act_jump, act_explore   chosen action / exploration flag, held until next act_valid
//  rew_valid, rew_good     reward for the outstanding decision
//  abort                   drop the outstanding decision without update
//  learn_en                0 freezes the table (rewards still consumed)
//  epsilon                 current exploration threshold
module qlearn_agent
  import qlearn_pkg::*;
#(
  parameter int              DIST_W       = 10,
  parameter int              SECTOR_SHIFT = 5,
  parameter int              NUM_SECTOR   = 32,
  parameter int              OBST_W       = 3,
  parameter int              NUM_OBST     = 3,
  parameter int              Q_W          = 8,
  parameter int              ALPHA_SHIFT  = 2,
  parameter int              EPS_INIT     = 16,
  parameter int              EPS_MIN      = 0,
  parameter longint unsigned EPS_PERIOD   = 64'd10000000000,
  parameter int              CNT_W        = 34
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIST_W-1:0] distance,
  input  logic [OBST_W-1:0] obst,
  output logic              act_valid,
  output logic              act_jump,
  output logic              act_explore,
  input  logic              rew_valid,
  input  logic              rew_good,
  input  logic              abort,
  input  logic              learn_en,
  output logic [7:0]        epsilon
);

  localparam int S_W     = (NUM_SECTOR > 1) ? $clog2(NUM_SECTOR) : 1;
  localparam int O_W     = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1;
  localparam int NUM_ENT = NUM_SECTOR * NUM_OBST * 2;
  localparam int IDX_W   = $clog2(NUM_ENT);

  localparam logic [Q_W-1:0]   QINIT     = Q_W'(q_init_val(Q_W));
  localparam logic [Q_W-1:0]   QMAX      = Q_W'(q_max_val(Q_W));
  localparam logic [7:0]       EPS_INIT8 = 8'(EPS_INIT);
  localparam logic [7:0]       EPS_MIN8  = 8'(EPS_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(EPS_PERIOD - 64'd1);

  // Move a fraction 2^-ALPHA_SHIFT of the way towards QMAX; cannot exceed QMAX.
  function automatic logic [Q_W-1:0] q_reward_good(input logic [Q_W-1:0] e);
    logic [Q_W-1:0] headroom;
    headroom = QMAX - e;
    return e + (headroom >> ALPHA_SHIFT);
  endfunction

  // Move a fraction 2^-ALPHA_SHIFT of the way towards zero; cannot go below 0.
  function automatic logic [Q_W-1:0] q_reward_bad(input logic [Q_W-1:0] e);
    return e - (e >> ALPHA_SHIFT);
  endfunction

  state_e            state_q, state_d;
  logic [DIST_W-1:0] sector_raw;
  logic [S_W-1:0]    sec_clamp, sec_q;
  logic [O_W-1:0]    obs_clamp, obs_q;
  logic              act_valid_q, act_jump_q, act_explore_q, rew_good_q;
  logic [Q_W-1:0]    q_q [NUM_ENT];
  logic [IDX_W-1:0]  base_idx, upd_idx;
  logic [Q_W-1:0]    q_nojump, q_jump, q_entry, q_new;
  logic [7:0]        rnd1, rnd2, eps_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              explore_d, act_d;

  lfsr8 #(.SEED(8'hA5)) u_rnd1 (.clk(clk), .reset(reset), .out(rnd1));
  lfsr8 #(.SEED(8'h3C)) u_rnd2 (.clk(clk), .reset(reset), .out(rnd2));

  // Request context clamping: out-of-range sectors/types fold onto the last row/column.
  assign sector_raw = distance >> SECTOR_SHIFT;

  always_comb begin
    sec_clamp = S_W'(sector_raw);
    if (sector_raw > DIST_W'(NUM_SECTOR - 1)) sec_clamp = S_W'(NUM_SECTOR - 1);
    obs_clamp = O_W'(obst);
    if (obst > OBST_W'(NUM_OBST - 1)) obs_clamp = O_W'(NUM_OBST - 1);
  end

  // Entries for one (sector, obstacle) pair sit side by side: even = no jump, odd = jump.
  assign base_idx = IDX_W'((int'(sec_q) * NUM_OBST + int'(obs_q)) * 2);
  assign q_nojump = q_q[base_idx];
  assign q_jump   = q_q[base_idx | IDX_W'(1)];

  // Explore with probability ~epsilon/256; upper half of rnd2 means jump.
  // Greedy ties resolve to no jump.
  assign explore_d = (eps_q > rnd1);
  assign act_d     = explore_d ? (rnd2 >= 8'h80) : (q_jump > q_nojump);

  assign upd_idx = base_idx | IDX_W'(act_jump_q);
  assign q_entry = q_q[upd_idx];
  assign q_new   = rew_good_q ? q_reward_good(q_entry) : q_reward_bad(q_entry);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = DECIDE;
      end
      DECIDE:   state_d = WAIT_REW;
      WAIT_REW: begin
        // abort takes priority over a simultaneous reward
        if (abort)          state_d = IDLE;
        else if (rew_valid) state_d = UPDATE;
      end
      UPDATE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_valid_q   <= 1'b0;
      act_jump_q    <= ACT_NOJUMP;
      act_explore_q <= 1'b0;
    end else begin
      act_valid_q <= (state_q == DECIDE);
      if (state_q == DECIDE) begin
        act_jump_q    <= act_d;
        act_explore_q <= explore_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      sec_q <= sec_clamp;
      obs_q <= obs_clamp;
    end
    if (state_q == WAIT_REW && rew_valid) rew_good_q <= rew_good;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENT; i++) q_q[i] <= QINIT;
    end else if (state_q == UPDATE && learn_en) begin
      q_q[upd_idx] <= q_new;
    end
  end

  // Epsilon decay timer runs regardless of the decision FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      eps_q <= EPS_INIT8;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      eps_q <= (eps_q > EPS_MIN8) ? eps_q - 8'd1 : EPS_MIN8;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign act_valid   = act_valid_q;
  assign act_jump    = act_jump_q;
  assign act_explore = act_explore_q;
  assign epsilon     = eps_q;

endmodule
